fir_mem_sequencer: RTL and testbench

FIR_MEM_SEQUENCER -- requirements
Module: fir_mem_sequencer

---
 rtl/fir_mem_sequencer_if.sv | 27 ++
 rtl/fir_mem_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_fir_mem_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mem_sequencer_if.sv
// Memory-side bus of the FIR sequencer: sample read port (master drives address)
// and result write port (master drives address, data and strobes).
interface fir_mem_sequencer_if #(
   parameter int DW = 12,
   parameter int AW = 8,
   parameter int OW = 22
);
   logic                 in_ce_n;
   logic [AW-1:0]        in_addr;
   logic signed [DW-1:0] in_data;
   logic                 out_ce_n;
   logic                 out_we_n;
   logic [AW-1:0]        out_addr;
   logic signed [OW-1:0] out_data;

   modport master (
      output in_ce_n, in_addr,
      input  in_data,
      output out_ce_n, out_we_n, out_addr, out_data
   );

   modport slave (
      input  in_ce_n, in_addr,
      output in_data,
      input  out_ce_n, out_we_n, out_addr, out_data
   );
endinterface

// File: rtl/fir_mem_sequencer.sv
// Memory-to-memory FIR filter: streams len samples from the input memory,
// filters them (direct or transposed form) and writes saturated results back.
module fir_mem_sequencer #(
   parameter int DW   = 12,
   parameter int CW   = 12,
   parameter int TAPS = 5,
   parameter int AW   = 8,
   parameter int OW   = 22
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic                    mode,
   input  logic [AW:0]             len,
   input  logic                    coef_we,
   input  logic [$clog2(TAPS)-1:0] coef_idx,
   input  logic signed [CW-1:0]    coef_data,
   fir_mem_sequencer_if.master     mem,
   output logic                    busy,
   output logic                    done,
   output logic                    sat_flag
);

   localparam int IW  = $clog2(TAPS);
   localparam int ACW = DW + CW + $clog2(TAPS);
   localparam int SW  = (ACW > OW) ? ACW : OW;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_FIN   = 2'd3;

   localparam logic [AW-1:0]      ADDR_ZERO = {AW{1'b0}};
   localparam logic [AW-1:0]      ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]        LEN_ZERO  = {(AW+1){1'b0}};
   localparam logic [AW:0]        LEN_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic signed [SW-1:0] SAT_MAX = SW'({1'b0, {(OW-1){1'b1}}});
   localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

   function automatic logic clamp_f(input logic signed [ACW-1:0] v);
      logic signed [SW-1:0] w;
      w = SW'(v);
      return (w > SAT_MAX) || (w < SAT_MIN);
   endfunction

   function automatic logic signed [OW-1:0] sat_f(input logic signed [ACW-1:0] v);
      logic signed [SW-1:0] w;
      w = SW'(v);
      if (w > SAT_MAX) begin
         w = SAT_MAX;
      end else if (w < SAT_MIN) begin
         w = SAT_MIN;
      end else begin
         w = SW'(v);
      end
      return w[OW-1:0];
   endfunction

   logic [1:0]            state_r;
   logic                  mode_r;
   logic [AW:0]           len_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  sat_r;
   logic                  in_ce_n_r;
   logic [AW-1:0]         in_addr_r;
   logic                  rd_vld_r;
   logic                  rd_last_r;
   logic [AW-1:0]         rd_addr_r;
   logic                  wr_last_r;
   logic                  out_ce_n_r;
   logic                  out_we_n_r;
   logic [AW-1:0]         out_addr_r;
   logic signed [OW-1:0]  out_data_r;

   logic signed [CW-1:0]  coef_r    [0:TAPS-1];
   logic signed [DW-1:0]  dly_r     [0:TAPS-2];
   logic signed [ACW-1:0] tps_r     [0:TAPS-2];
   logic signed [ACW-1:0] tps_nxt_s [0:TAPS-2];
   logic signed [ACW-1:0] prod_s    [0:TAPS-1];
   logic signed [ACW-1:0] acc_dir_s;
   logic signed [ACW-1:0] acc_s;
   logic signed [DW-1:0]  x_s;
   logic                  sat_hit_s;
   logic signed [OW-1:0]  y_s;
   logic                  start_ok_s;
   logic                  last_addr_s;

   assign x_s         = mem.in_data;
   assign start_ok_s  = (state_r == ST_IDLE) && start;
   assign last_addr_s = ({1'b0, in_addr_r} == (len_r - LEN_ONE));

   // Both filter structures from the sample arriving this cycle; mode picks the result
   always_comb begin
      for (int k = 0; k < TAPS; k++) begin
         prod_s[k] = ACW'(coef_r[k]) * ACW'(x_s);
      end
      acc_dir_s = prod_s[0];
      for (int k = 1; k < TAPS; k++) begin
         acc_dir_s = acc_dir_s + ACW'(coef_r[k]) * ACW'(dly_r[k-1]);
      end
      for (int k = 0; k < TAPS-2; k++) begin
         tps_nxt_s[k] = prod_s[k+1] + tps_r[k+1];
      end
      tps_nxt_s[TAPS-2] = prod_s[TAPS-1];
      if (mode_r) begin
         acc_s = prod_s[0] + tps_r[0];
      end else begin
         acc_s = acc_dir_s;
      end
      sat_hit_s = clamp_f(acc_s);
      y_s       = sat_f(acc_s);
   end

   // Sequencer FSM, address generation, write port and status flags
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         state_r    <= ST_IDLE;
         mode_r     <= 1'b0;
         len_r      <= LEN_ZERO;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         sat_r      <= 1'b0;
         in_ce_n_r  <= 1'b1;
         in_addr_r  <= ADDR_ZERO;
         rd_vld_r   <= 1'b0;
         rd_last_r  <= 1'b0;
         rd_addr_r  <= ADDR_ZERO;
         wr_last_r  <= 1'b0;
         out_ce_n_r <= 1'b1;
         out_we_n_r <= 1'b1;
         out_addr_r <= ADDR_ZERO;
         out_data_r <= {OW{1'b0}};
      end else begin
         rd_vld_r  <= (state_r == ST_RUN);
         rd_last_r <= (state_r == ST_RUN) && last_addr_s;
         rd_addr_r <= in_addr_r;
         if (rd_vld_r) begin
            out_ce_n_r <= 1'b0;
            out_we_n_r <= 1'b0;
            out_addr_r <= rd_addr_r;
            out_data_r <= y_s;
            wr_last_r  <= rd_last_r;
            if (sat_hit_s) begin
               sat_r <= 1'b1;
            end
         end else begin
            out_ce_n_r <= 1'b1;
            out_we_n_r <= 1'b1;
            wr_last_r  <= 1'b0;
         end
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  mode_r <= mode;
                  len_r  <= len;
                  busy_r <= 1'b1;
                  sat_r  <= 1'b0;
                  if (len == LEN_ZERO) begin
                     state_r <= ST_FIN;
                     done_r  <= 1'b1;
                  end else begin
                     state_r   <= ST_RUN;
                     in_ce_n_r <= 1'b0;
                     in_addr_r <= ADDR_ZERO;
                  end
               end
            end
            ST_RUN: begin
               if (last_addr_s) begin
                  state_r   <= ST_DRAIN;
                  in_ce_n_r <= 1'b1;
               end else begin
                  in_addr_r <= in_addr_r + ADDR_ONE;
               end
            end
            ST_DRAIN: begin
               // wr_last_r marks the final write being presented this cycle
               if (wr_last_r) begin
                  state_r <= ST_FIN;
                  done_r  <= 1'b1;
               end
            end
            ST_FIN: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r   <= ST_IDLE;
               in_ce_n_r <= 1'b1;
               done_r    <= 1'b0;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

   // Delay line / transposed partial sums: cleared per run, advanced per sample
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         for (int k = 0; k < TAPS-1; k++) begin
            dly_r[k] <= {DW{1'b0}};
            tps_r[k] <= {ACW{1'b0}};
         end
      end else if (start_ok_s) begin
         for (int k = 0; k < TAPS-1; k++) begin
            dly_r[k] <= {DW{1'b0}};
            tps_r[k] <= {ACW{1'b0}};
         end
      end else if (rd_vld_r) begin
         dly_r[0] <= x_s;
         for (int k = 1; k < TAPS-1; k++) begin
            dly_r[k] <= dly_r[k-1];
         end
         for (int k = 0; k < TAPS-1; k++) begin
            tps_r[k] <= tps_nxt_s[k];
         end
      end
   end

   // Coefficient bank, writable only while idle and only for valid indices
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         for (int k = 0; k < TAPS; k++) begin
            coef_r[k] <= {CW{1'b0}};
         end
      end else if ((state_r == ST_IDLE) && coef_we && (int'(coef_idx) < TAPS)) begin
         coef_r[coef_idx] <= coef_data;
      end
   end

   assign mem.in_ce_n  = in_ce_n_r;
   assign mem.in_addr  = in_addr_r;
   assign mem.out_ce_n = out_ce_n_r;
   assign mem.out_we_n = out_we_n_r;
   assign mem.out_addr = out_addr_r;
   assign mem.out_data = out_data_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign sat_flag     = sat_r;

   logic unused_iw_s;
   assign unused_iw_s = (IW == 0);

endmodule

// File: tb/tb_fir_mem_sequencer.sv
// Directed bench for fir_mem_sequencer: behavioural memories, a write/issue
// monitor and one task per scenario with hand-derived expectations.
module tb_fir_mem_sequencer;
   localparam int DW = 12, CW = 12, TAPS = 5, AW = 8, OW = 22;

   logic              clk = 1'b0;
   logic              rstn = 1'b1;
   logic              start = 1'b0;
   logic              mode = 1'b0;
   logic [AW:0]       len = 9'd0;
   logic              coef_we = 1'b0;
   logic [2:0]        coef_idx = 3'd0;
   logic signed [CW-1:0] coef_data = 12'sd0;
   logic              busy, done, sat_flag;

   fir_mem_sequencer_if #(.DW(DW), .AW(AW), .OW(OW)) mem_if ();

   fir_mem_sequencer #(.DW(DW), .CW(CW), .TAPS(TAPS), .AW(AW), .OW(OW)) dut (
      .clk(clk), .rstn(rstn), .start(start), .mode(mode), .len(len),
      .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
      .mem(mem_if), .busy(busy), .done(done), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int x_tb [0:255];
   int coef_tb [0:TAPS-1];

   int iss_cnt, wr_cnt, done_cnt, busy_cnt, strobe_bad, done_cyc, acc_cyc;
   int iss_addr [0:299];
   int iss_cyc  [0:299];
   int wr_addr  [0:299];
   int wr_cyc   [0:299];
   int wr_data  [0:299];
   logic wr_sat [0:299];
   logic sat_at_start;
   int ref_data [0:7];

   always @(posedge clk) cyc <= cyc + 1;

   // input memory: read data valid the cycle after the address
   always @(posedge clk) begin
      if (mem_if.in_ce_n === 1'b0) mem_if.in_data <= DW'(x_tb[mem_if.in_addr]);
   end

   always @(negedge clk) begin
      if (mem_if.in_ce_n === 1'b0 && iss_cnt < 300) begin
         iss_addr[iss_cnt] = int'(mem_if.in_addr);
         iss_cyc[iss_cnt]  = cyc;
         iss_cnt++;
      end
      if (mem_if.out_we_n === 1'b0 && mem_if.out_ce_n === 1'b0 && wr_cnt < 300) begin
         wr_addr[wr_cnt] = int'(mem_if.out_addr);
         wr_data[wr_cnt] = int'(mem_if.out_data);
         wr_cyc[wr_cnt]  = cyc;
         wr_sat[wr_cnt]  = sat_flag;
         wr_cnt++;
      end
      if (mem_if.out_we_n !== mem_if.out_ce_n) strobe_bad++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   function automatic int model_y(int n);
      longint acc = 0;
      for (int k = 0; k < TAPS; k++) begin
         if (n - k >= 0) acc += longint'(coef_tb[k]) * longint'(x_tb[n-k]);
      end
      if (acc > 64'sd2097151) acc = 64'sd2097151;
      else if (acc < -64'sd2097152) acc = -64'sd2097152;
      return int'(acc);
   endfunction

   task automatic clear_log();
      iss_cnt = 0; wr_cnt = 0; done_cnt = 0; busy_cnt = 0; strobe_bad = 0; done_cyc = -1;
   endtask

   task automatic set_coefs(input int c0, input int c1, input int c2, input int c3, input int c4);
      coef_tb[0] = c0; coef_tb[1] = c1; coef_tb[2] = c2; coef_tb[3] = c3; coef_tb[4] = c4;
      for (int k = 0; k < TAPS; k++) begin
         @(negedge clk);
         coef_we = 1'b1; coef_idx = 3'(k); coef_data = CW'(coef_tb[k]);
      end
      @(negedge clk);
      coef_idx = 3'd7; coef_data = 12'sd999;
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   task automatic run_seq(input logic m, input logic [AW:0] l, input bit disturb);
      int n;
      clear_log();
      @(negedge clk);
      mode = m; len = l; start = 1'b1;
      @(posedge clk);
      #1;
      acc_cyc = cyc; sat_at_start = sat_flag; start = 1'b0;
      n = 0;
      while (done_cnt == 0 && n < 2000) begin
         @(negedge clk);
         n++;
         if (disturb && n == 3) begin
            start = 1'b1; mode = ~m; len = 9'd3;
            coef_we = 1'b1; coef_idx = 3'd0; coef_data = 12'sd77;
         end else if (disturb && n == 4) begin
            start = 1'b0; coef_we = 1'b0; mode = m;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, sat_flag, mem_if.in_ce_n, mem_if.out_ce_n, mem_if.out_we_n} !== 6'b000111) begin
         failures++;
         $display("FAIL reset_ctrl: got %b expected 000111",
                  {busy, done, sat_flag, mem_if.in_ce_n, mem_if.out_ce_n, mem_if.out_we_n});
      end
      checks++;
      if (mem_if.in_addr !== 8'd0 || mem_if.out_addr !== 8'd0 || mem_if.out_data !== 22'd0) begin
         failures++;
         $display("FAIL reset_bus: in_addr %0d out_addr %0d out_data %0d expected 0 0 0",
                  mem_if.in_addr, mem_if.out_addr, mem_if.out_data);
      end
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, mem_if.in_ce_n, mem_if.out_we_n} !== 4'b0011) begin
         failures++;
         $display("FAIL reset_release_idle: got %b expected 0011",
                  {busy, done, mem_if.in_ce_n, mem_if.out_we_n});
      end
   endtask

   task automatic test_impulse();
      int exp_imp [0:7] = '{1, 2, 3, 4, 5, 0, 0, 0};
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 256; i++) x_tb[i] = 0;
         x_tb[0] = 1;
         set_coefs(1, 2, 3, 4, 5);
         run_seq(1'(m), 9'd8, 1'b0);
         checks++;
         if (wr_cnt !== 8 || iss_cnt !== 8 || done_cnt !== 1) begin
            failures++;
            $display("FAIL impulse_counts m%0d: writes %0d issues %0d dones %0d expected 8 8 1",
                     m, wr_cnt, iss_cnt, done_cnt);
         end
         checks++;
         if (busy_cnt !== 11 || iss_cyc[0] !== acc_cyc || done_cyc !== wr_cyc[7] + 1) begin
            failures++;
            $display("FAIL impulse_timing m%0d: busy %0d addr0@%0d done@%0d expected 11 %0d %0d",
                     m, busy_cnt, iss_cyc[0], done_cyc, acc_cyc, wr_cyc[7] + 1);
         end
         checks++;
         if (strobe_bad !== 0) begin
            failures++;
            $display("FAIL impulse_strobes m%0d: %0d cycles with out_we_n != out_ce_n, expected 0", m, strobe_bad);
         end
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (wr_addr[i] !== i || iss_addr[i] !== i || wr_cyc[i] !== iss_cyc[i] + 2) begin
               failures++;
               $display("FAIL impulse_addr m%0d[%0d]: wr_addr %0d iss_addr %0d wr@%0d expected %0d %0d %0d",
                        m, i, wr_addr[i], iss_addr[i], wr_cyc[i], i, i, iss_cyc[i] + 2);
            end
            checks++;
            if (wr_data[i] !== exp_imp[i]) begin
               failures++;
               $display("FAIL impulse_data m%0d[%0d]: got %0d expected %0d", m, i, wr_data[i], exp_imp[i]);
            end
         end
      end
   endtask

   task automatic test_pos_sat();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 256; i++) x_tb[i] = (i < 6) ? 2047 : 0;
         set_coefs(2047, 2047, 2047, 2047, 2047);
         run_seq(1'(m), 9'd6, 1'b0);
         checks++;
         if (wr_cnt !== 6 || wr_sat[0] !== 1'b1 || sat_flag !== 1'b1) begin
            failures++;
            $display("FAIL pos_sat_flag m%0d: writes %0d sat@first %b sat_end %b expected 6 1 1",
                     m, wr_cnt, wr_sat[0], sat_flag);
         end
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (wr_data[i] !== 2097151) begin
               failures++;
               $display("FAIL pos_sat_data m%0d[%0d]: got %0d expected 2097151", m, i, wr_data[i]);
            end
         end
      end
   endtask

   task automatic test_neg_sat();
      for (int i = 0; i < 256; i++) x_tb[i] = (i < 5) ? -2048 : 0;
      set_coefs(2047, 2047, 2047, 2047, 2047);
      run_seq(1'b1, 9'd5, 1'b0);
      checks++;
      if (wr_cnt !== 5 || sat_flag !== 1'b1) begin
         failures++;
         $display("FAIL neg_sat_flag: writes %0d sat %b expected 5 1", wr_cnt, sat_flag);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (wr_data[i] !== -2097152) begin
            failures++;
            $display("FAIL neg_sat_data[%0d]: got %0d expected -2097152", i, wr_data[i]);
         end
      end
      set_coefs(0, 0, 0, 0, 0);
      run_seq(1'b0, 9'd5, 1'b0);
      checks++;
      if (sat_at_start !== 1'b0 || sat_flag !== 1'b0 || wr_cnt !== 5) begin
         failures++;
         $display("FAIL zero_coef_sat: sat@start %b sat_end %b writes %0d expected 0 0 5",
                  sat_at_start, sat_flag, wr_cnt);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (wr_data[i] !== 0) begin
            failures++;
            $display("FAIL zero_coef_data[%0d]: got %0d expected 0", i, wr_data[i]);
         end
      end
   endtask

   task automatic test_len_zero();
      run_seq(1'b0, 9'd0, 1'b0);
      checks++;
      if (busy_cnt !== 1 || done_cnt !== 1 || done_cyc !== acc_cyc) begin
         failures++;
         $display("FAIL len0_handshake: busy %0d dones %0d done@%0d expected 1 1 %0d",
                  busy_cnt, done_cnt, done_cyc, acc_cyc);
      end
      checks++;
      if (iss_cnt !== 0 || wr_cnt !== 0 || strobe_bad !== 0) begin
         failures++;
         $display("FAIL len0_no_access: issues %0d writes %0d bad strobes %0d expected 0 0 0",
                  iss_cnt, wr_cnt, strobe_bad);
      end
   endtask

   task automatic test_len_full();
      for (int i = 0; i < 256; i++) x_tb[i] = ((i * 37 + 5) % 4001) - 2000;
      set_coefs(3, -7, 11, -2, 5);
      run_seq(1'b1, 9'd256, 1'b0);
      checks++;
      if (wr_cnt !== 256 || iss_cnt !== 256 || done_cnt !== 1 || iss_addr[255] !== 255) begin
         failures++;
         $display("FAIL len256_counts: writes %0d issues %0d dones %0d last addr %0d expected 256 256 1 255",
                  wr_cnt, iss_cnt, done_cnt, iss_addr[255]);
      end
      for (int i = 0; i < 256; i++) begin
         checks++;
         if (wr_addr[i] !== i || wr_data[i] !== model_y(i)) begin
            failures++;
            $display("FAIL len256_write[%0d]: addr %0d data %0d expected %0d %0d",
                     i, wr_addr[i], wr_data[i], i, model_y(i));
         end
      end
   endtask

   task automatic test_reset_midrun();
      int n, wr_snap, iss_snap;
      for (int i = 0; i < 256; i++) x_tb[i] = (i < 8) ? (i * 100 - 350) : 0;
      set_coefs(1, -1, 2, -2, 3);
      clear_log();
      @(negedge clk);
      mode = 1'b0; len = 9'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (n = 0; n < 40 && !(mem_if.in_ce_n === 1'b0 && mem_if.in_addr === 8'd3); n++) @(negedge clk);
      checks++;
      if (n >= 40) begin
         failures++;
         $display("FAIL midrun_reach_addr3: waited %0d cycles, expected under 40", n);
      end
      rstn = 1'b1;
      #1;
      wr_snap = wr_cnt; iss_snap = iss_cnt;
      checks++;
      if ({busy, done, sat_flag, mem_if.in_ce_n, mem_if.out_ce_n, mem_if.out_we_n} !== 6'b000111 ||
          mem_if.in_addr !== 8'd0 || mem_if.out_data !== 22'd0) begin
         failures++;
         $display("FAIL midrun_reset_now: ctrl %b in_addr %0d out_data %0d expected 000111 0 0",
                  {busy, done, sat_flag, mem_if.in_ce_n, mem_if.out_ce_n, mem_if.out_we_n},
                  mem_if.in_addr, mem_if.out_data);
      end
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (done_cnt !== 0 || wr_cnt !== wr_snap || iss_cnt !== iss_snap) begin
         failures++;
         $display("FAIL midrun_abort: dones %0d writes %0d issues %0d expected 0 %0d %0d",
                  done_cnt, wr_cnt, iss_cnt, wr_snap, iss_snap);
      end
      // coefficients were cleared by reset: a bare rerun filters to all zeros
      run_seq(1'b0, 9'd8, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (wr_data[i] !== 0) begin
            failures++;
            $display("FAIL midrun_coef_cleared[%0d]: got %0d expected 0", i, wr_data[i]);
         end
      end
      set_coefs(1, -1, 2, -2, 3);
      run_seq(1'b0, 9'd8, 1'b0);
      checks++;
      if (wr_cnt !== 8 || done_cnt !== 1) begin
         failures++;
         $display("FAIL midrun_rerun_counts: writes %0d dones %0d expected 8 1", wr_cnt, done_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (wr_data[i] !== model_y(i)) begin
            failures++;
            $display("FAIL midrun_rerun_data[%0d]: got %0d expected %0d", i, wr_data[i], model_y(i));
         end
      end
   endtask

   task automatic test_ignore_midrun();
      for (int i = 0; i < 256; i++) x_tb[i] = (i < 8) ? (1500 - i * 411) : 0;
      set_coefs(2, 0, -3, 1, 4);
      run_seq(1'b0, 9'd8, 1'b0);
      for (int i = 0; i < 8; i++) ref_data[i] = wr_data[i];
      run_seq(1'b0, 9'd8, 1'b1);
      checks++;
      if (wr_cnt !== 8 || done_cnt !== 1 || iss_cnt !== 8) begin
         failures++;
         $display("FAIL ignore_counts: writes %0d dones %0d issues %0d expected 8 1 8", wr_cnt, done_cnt, iss_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (wr_data[i] !== ref_data[i] || wr_data[i] !== model_y(i)) begin
            failures++;
            $display("FAIL ignore_data[%0d]: got %0d expected %0d", i, wr_data[i], model_y(i));
         end
      end
   endtask

   initial begin
      clear_log();
      test_reset();
      test_impulse();
      test_pos_sat();
      test_neg_sat();
      test_len_zero();
      test_len_full();
      test_reset_midrun();
      test_ignore_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
